// File: rtl/serial_shifter.sv
// Multi-cycle serial shifter: shifts a 32-bit operand one bit per clock (SLL/SRL/SRA/ROR).
// Define SERIAL_SHIFTER_ROR_EN to enable rotate-right on op=11; otherwise op=11 is a pass-through.
module serial_shifter #(
  parameter int unsigned SHAMT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [31:0]        data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [31:0]        data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [31:0] data_q;
  logic [4:0]  count_q;
  logic [1:0]  op_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] shift_d;
  logic        pass_d;

  // Upper shift-amount bits are don't-care.
  if (SHAMT_W > 5) begin : g_unused
    logic unused_shamt;
    assign unused_shamt = ^shamt[SHAMT_W-1:5];
  end

  always_comb begin
    shift_d = data_q;
    unique case (op_q)
      2'b00: shift_d = {data_q[30:0], 1'b0};
      2'b01: shift_d = {1'b0, data_q[31:1]};
      2'b10: shift_d = {data_q[31], data_q[31:1]};
      2'b11: begin
`ifdef SERIAL_SHIFTER_ROR_EN
        shift_d = {data_q[0], data_q[31:1]};
`else
        shift_d = data_q;
`endif
      end
      default: shift_d = data_q;
    endcase
  end

  // A start completes immediately when there is nothing to shift.
  always_comb begin
`ifdef SERIAL_SHIFTER_ROR_EN
    pass_d = (shamt[4:0] == 5'd0);
`else
    pass_d = (shamt[4:0] == 5'd0) || (op == 2'b11);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= 32'h0;
      count_q <= 5'd0;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            data_q  <= data_in;
            count_q <= shamt[4:0];
            op_q    <= op;
            if (pass_d) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StShift;
              busy_q  <= 1'b1;
            end
          end
        end
        StShift: begin
          data_q  <= shift_d;
          count_q <= count_q - 5'd1;
          if (count_q == 5'd1) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
